// File: rtl/mult_div_unit.sv
// Multicycle 32-bit multiply/divide unit feeding the HI/LO registers.
// Shift-add multiplier and restoring divider, 32 iterations plus a sign-fix cycle.
module mult_div_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Op,
  input  logic        SignedOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_op;
  logic        r_neg;
  logic        r_rneg;
  logic [4:0]  r_cnt;
  logic [31:0] r_b;
  logic [63:0] r_acc;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_msum;
  logic [32:0] w_dsh;
  logic        w_ge;
  logic [31:0] w_dsub;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_a_neg = SignedOp & A[31];
  assign w_b_neg = SignedOp & B[31];
  assign w_a_mag = w_a_neg ? -A : A;
  assign w_b_mag = w_b_neg ? -B : B;

  // Low accumulator half holds the multiplier (mul) or quotient (div)
  assign w_msum = {1'b0, r_acc[63:32]}
                + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_dsh  = r_acc[63:31];
  assign w_ge   = w_dsh >= {1'b0, r_b};
  assign w_dsub = w_dsh[31:0] - r_b;

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem  = r_rneg ? -r_acc[63:32] : r_acc[63:32];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_neg   <= 1'b0;
      r_rneg  <= 1'b0;
      r_cnt   <= 5'd0;
      r_b     <= 32'd0;
      r_acc   <= 64'd0;
      Hi      <= 32'd0;
      Lo      <= 32'd0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          Done <= 1'b0;
          if (Start) begin
            r_op    <= Op;
            r_cnt   <= 5'd0;
            DivZero <= 1'b0;
            if (Op && B == 32'd0) begin
              r_state <= S_DONE;
              Done    <= 1'b1;
              DivZero <= 1'b1;
            end else begin
              r_neg   <= w_a_neg ^ w_b_neg;
              r_rneg  <= w_a_neg;
              r_b     <= Op ? w_b_mag : w_a_mag;
              r_acc   <= {32'd0, Op ? w_a_mag : w_b_mag};
              Busy    <= 1'b1;
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (!r_op)
            r_acc <= {w_msum, r_acc[31:1]};
          else if (w_ge)
            r_acc <= {w_dsub, r_acc[30:0], 1'b1};
          else
            r_acc <= {w_dsh[31:0], r_acc[30:0], 1'b0};
          if (r_cnt == 5'd31)
            r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_op) begin
            Hi <= w_rem;
            Lo <= w_quo;
          end else begin
            Hi <= w_prod[63:32];
            Lo <= w_prod[31:0];
          end
          Busy    <= 1'b0;
          Done    <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit.
// Hand-computed HI/LO results, latency and flag checks.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Op = 1'b0;
  logic        SignedOp = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int n_chk  = 0;
  int n_fail = 0;
  int lat;
  int busyc;
  int seen;

  mult_div_unit dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .SignedOp (SignedOp),
    .A        (A),
    .B        (B),
    .Hi       (Hi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    lat++;
    if (Busy) busyc++;
  endtask

  task automatic launch(input logic op, input logic sg,
                        input logic [31:0] a,
                        input logic [31:0] b);
    Op = op;
    SignedOp = sg;
    A = a;
    B = b;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    lat = 0;
    busyc = Busy ? 1 : 0;
  endtask

  task automatic wait_done();
    while (!Done && lat < 100) tick();
  endtask

  task automatic run(input logic op, input logic sg,
                     input logic [31:0] a,
                     input logic [31:0] b);
    launch(op, sg, a, b);
    wait_done();
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_dz", {31'd0, DivZero}, 32'd0);
    Reset = 1'b0;

    run(1'b0, 1'b1, 32'd7, 32'hFFFFFFFD);
    chk("mult_lat", lat, 32'd33);
    chk("mult_busy", busyc, 32'd33);
    chk("mult_hi", Hi, 32'hFFFFFFFF);
    chk("mult_lo", Lo, 32'hFFFFFFEB);
    tick();
    chk("done_fall", {31'd0, Done}, 32'd0);
    chk("idle_busy", {31'd0, Busy}, 32'd0);

    run(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi", Hi, 32'hFFFFFFFE);
    chk("multu_lo", Lo, 32'h00000001);
    tick();
    run(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mults_hi", Hi, 32'd0);
    chk("mults_lo", Lo, 32'd1);
    tick();

    run(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
    chk("div_lat", lat, 32'd33);
    chk("div_lo", Lo, 32'hFFFFFFFD);
    chk("div_hi", Hi, 32'hFFFFFFFF);
    tick();
    run(1'b1, 1'b0, 32'd100, 32'd7);
    chk("divu_lo", Lo, 32'h0000000E);
    chk("divu_hi", Hi, 32'h00000002);
    tick();
    run(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    chk("ovf_lo", Lo, 32'h80000000);
    chk("ovf_hi", Hi, 32'd0);
    chk("ovf_dz", {31'd0, DivZero}, 32'd0);
    tick();

    // 0x22222222 * 0x80000001 = 0x11111111_22222222
    run(1'b0, 1'b0, 32'h22222222, 32'h80000001);
    chk("pre_hi", Hi, 32'h11111111);
    chk("pre_lo", Lo, 32'h22222222);
    tick();
    run(1'b1, 1'b1, 32'd55, 32'd0);
    chk("dz_lat", lat, 32'd0);
    chk("dz_done", {31'd0, Done}, 32'd1);
    chk("dz_flag", {31'd0, DivZero}, 32'd1);
    chk("dz_busy", busyc, 32'd0);
    chk("dz_hi", Hi, 32'h11111111);
    chk("dz_lo", Lo, 32'h22222222);
    launch(1'b1, 1'b0, 32'd100, 32'd7);
    chk("dz_clr", {31'd0, DivZero}, 32'd0);
    chk("dz_next_busy", {31'd0, Busy}, 32'd1);
    wait_done();
    chk("dz_next_lo", Lo, 32'h0000000E);
    tick();

    launch(1'b0, 1'b0, 32'd6, 32'd7);
    repeat (10) tick();
    Op = 1'b1;
    A = 32'd100;
    B = 32'd100;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done();
    chk("ign_lat", lat, 32'd33);
    chk("ign_hi", Hi, 32'd0);
    chk("ign_lo", Lo, 32'd42);

    launch(1'b1, 1'b0, 32'd100, 32'd7);
    chk("b2b_busy", {31'd0, Busy}, 32'd1);
    wait_done();
    chk("b2b_lat", lat, 32'd33);
    chk("b2b_lo", Lo, 32'h0000000E);
    chk("b2b_hi", Hi, 32'h00000002);
    tick();

    launch(1'b0, 1'b0, 32'd3, 32'd5);
    repeat (9) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mrst_busy", {31'd0, Busy}, 32'd0);
    chk("mrst_done", {31'd0, Done}, 32'd0);
    chk("mrst_hi", Hi, 32'd0);
    chk("mrst_lo", Lo, 32'd0);
    chk("mrst_dz", {31'd0, DivZero}, 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (Done) seen++;
    end
    chk("mrst_nodone", seen, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle integer multiply/divide unit for the MIPS multicycle datapath, downstream of the A/B operand registers and alongside the ALU. It implements mult, multu, div and divu using a 32-iteration shift-add multiplier and a 32-iteration restoring divider, and writes results to the HI/LO registers. The control unit starts an operation with a one-cycle Start pulse and holds in a wait state until Done. The write-back mux reads HI/LO for mfhi/mflo.

## Interface

Parameters:
- None. Width is fixed at 32 bits.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high; clears all state on the rising edge of Clk.
- Start  in  1  start request; sampled only in IDLE or DONE.
- Op  in  1  0 = multiply, 1 = divide; sampled with Start.
- SignedOp  in  1  1 = two's-complement (mult/div), 0 = unsigned (multu/divu); sampled with Start.
- A  in  32  multiplicand or dividend, from register A; sampled with Start.
- B  in  32  multiplier or divisor, from register B; sampled with Start.
- Hi  out  32  HI register: upper product word, or remainder.
- Lo  out  32  LO register: lower product word, or quotient.
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse; Hi/Lo are valid in the same cycle.
- DivZero  out  1  sticky flag for divide by zero; cleared by the next accepted Start.

## Operation

- FSM states: IDLE, CALC, FIX, DONE.
- Reset values: state = IDLE, Hi = 0, Lo = 0, Busy = 0, Done = 0, DivZero = 0, iteration counter = 0.
- **IDLE or DONE, Start = 1:**
  - Latch Op and SignedOp.
  - When SignedOp = 1, latch the operand magnitudes and record the result signs.
  - Clear DivZero and the counter.
  - Next state is CALC.
  - Exception: Op = 1 and B = 0 goes directly to DONE with DivZero = 1, and Hi/Lo hold their previous values.
- **IDLE or DONE, Start = 0:** next state is IDLE.
- **CALC, multiply:** each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half of a 64-bit accumulator (with a 33-bit carry), then shift right by one.
- **CALC, divide:**
  - Each cycle, shift the {remainder, quotient} pair left by one and trial-subtract the divisor from the 33-bit remainder.
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore.
- **CALC exit:** the counter increments every cycle; after 32 CALC cycles the next state is FIX.
- **FIX:** apply sign correction and load the results.
  - mult: negate the 64-bit product if the operand signs differ; write {Hi, Lo} = product.
  - div: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative; write Lo = quotient, Hi = remainder.
  - Next state is DONE.
- **DONE:** Done = 1 for this one cycle, and Busy = 0. A Start seen here is accepted exactly as in IDLE, allowing back-to-back operations.
- **Busy:** Busy = 1 in CALC and FIX. A Start during Busy is ignored, and operands are not re-sampled.
- **Signed-division semantics:**
  - Quotient truncates toward zero, and the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0. The result wraps and no flag is raised.
- **Hi/Lo hold rule:** Hi and Lo change only in FIX or on Reset. Between operations they hold their values indefinitely.
- **Reset during any state:** state returns to IDLE, all outputs take their reset values, and the partial result is discarded.

## Timing

- Start is accepted at edge k.
- Busy = 1 from after edge k through edge k+32: 32 CALC cycles plus 1 FIX cycle.
- Edge k+33 loads Hi/Lo and enters DONE. Done = 1 in the cycle after edge k+33, Busy = 0.
- Edge k+34 returns to IDLE (or enters CALC if Start = 1), and Done falls.
- Fixed latency: 34 edges from Start to the end of the Done pulse, independent of operand values or signedness.
- Divide by zero: edge k enters DONE. Done = 1 and DivZero = 1 in the cycle after edge k.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan

- **Signed mult:** SignedOp = 1, Op = 0, A = 7, B = 0xFFFFFFFD → Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB. Done is high exactly in the cycle after edge k+33, and Busy = 1 for exactly 33 cycles.
- **Unsigned mult:** multu with A = B = 0xFFFFFFFF → Hi = 0xFFFFFFFE, Lo = 0x00000001. Repeat with signed mult → Hi = 0, Lo = 1.
- **Division:**
  - Signed div, A = 0xFFFFFFF9 (-7), B = 2 → Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF.
  - divu, A = 100, B = 7 → Lo = 0x0000000E, Hi = 0x00000002.
  - Signed div, A = 0x80000000, B = 0xFFFFFFFF → Lo = 0x80000000, Hi = 0.
- **Divide by zero:**
  - Preload Hi/Lo = 0x11111111 / 0x22222222, then div with B = 0 → Done and DivZero high in the cycle after edge k; Hi/Lo are unchanged.
  - A subsequent valid Start clears DivZero.
- **Start during Busy:** a Start pulse with new operands 10 cycles into an operation is ignored, and the results match the first operands. A Start in the DONE cycle launches a second operation with no idle gap.
- **Reset mid-operation:** assert Reset on CALC cycle 10 → the next cycle shows Busy = 0, Done = 0, Hi = Lo = 0, DivZero = 0, and no Done pulse appears afterward.
